half_adder_fault: RTL and testbench

HALF_ADDER_FAULT -- requirements
Module: half_adder_fault

---
 rtl/half_adder_fault_pkg.sv | 33 +++
 rtl/half_adder_core.sv | 12 +
 rtl/half_adder_fault.sv | 81 ++++++++
 tb/tb_half_adder_fault.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/half_adder_fault_pkg.sv
// Fault-injection encodings and the per-bit fault transform shared by the half-adder slice.
// No state; pure constants, types and a combinational helper.
package half_adder_fault_pkg;

  localparam logic [1:0] SEL_NONE  = 2'b00;
  localparam logic [1:0] SEL_SUM   = 2'b01;
  localparam logic [1:0] SEL_CARRY = 2'b10;
  localparam logic [1:0] SEL_BOTH  = 2'b11;

  typedef enum logic [1:0] {
    FT_NONE = 2'b00,
    FT_SA0  = 2'b01,
    FT_SA1  = 2'b10,
    FT_INV  = 2'b11
  } fault_type_t;

  function automatic logic apply_fault(input logic golden, input fault_type_t ftype);
    logic res;
    res = golden;
    case (ftype)
      FT_SA0:  res = 1'b0;
      FT_SA1:  res = 1'b1;
      FT_INV:  res = ~golden;
      default: res = golden;
    endcase
    return res;
  endfunction

  function automatic logic fault_armed(input logic [1:0] sel, input fault_type_t ftype);
    return (sel != SEL_NONE) && (ftype != FT_NONE);
  endfunction

endpackage

// File: rtl/half_adder_core.sv
// Fault-free half adder; purely combinational, zero latency.
module half_adder_core (
  input  logic a,
  input  logic b,
  output logic sum,
  output logic carry
);

  assign sum   = a ^ b;
  assign carry = a & b;

endmodule

// File: rtl/half_adder_fault.sv
// Half adder with configurable stuck-at/invert fault injection and mismatch tracking.
// Outputs combinational; fault config, mismatch flag and counter update one clk after their cause.
module half_adder_fault
  import half_adder_fault_pkg::*;
#(
  parameter int DUR_W = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             a,
  input  logic             b,
  output logic             sum,
  output logic             carry,
  output logic             sum_golden,
  output logic             carry_golden,
  input  logic             fault_we,
  input  logic [1:0]       fault_sel,
  input  logic [1:0]       fault_type,
  input  logic [DUR_W-1:0] fault_dur,
  output logic             fault_active,
  output logic             mismatch,
  output logic [CNT_W-1:0] mismatch_cnt
);

  logic [1:0]       cfg_sel;
  fault_type_t      cfg_type;
  logic [DUR_W-1:0] dur_cnt;
  logic             mismatch_now;

  half_adder_core u_core (
    .a     (a),
    .b     (b),
    .sum   (sum_golden),
    .carry (carry_golden)
  );

  always_comb begin
    sum   = sum_golden;
    carry = carry_golden;
    if (fault_active) begin
      if ((cfg_sel & SEL_SUM) != SEL_NONE)
        sum = apply_fault(sum_golden, cfg_type);
      if ((cfg_sel & SEL_CARRY) != SEL_NONE)
        carry = apply_fault(carry_golden, cfg_type);
    end
  end

  assign mismatch_now = (sum != sum_golden) || (carry != carry_golden);

  // dur_cnt == 0 while active means permanent; a nonzero count expires the fault on reaching 1.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cfg_sel      <= SEL_NONE;
      cfg_type     <= FT_NONE;
      dur_cnt      <= '0;
      fault_active <= 1'b0;
    end else if (fault_we) begin
      cfg_sel      <= fault_sel;
      cfg_type     <= fault_type_t'(fault_type);
      dur_cnt      <= fault_dur;
      fault_active <= fault_armed(fault_sel, fault_type_t'(fault_type));
    end else if (fault_active && (dur_cnt != '0)) begin
      dur_cnt <= dur_cnt - 1'b1;
      if (dur_cnt == DUR_W'(1))
        fault_active <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mismatch     <= 1'b0;
      mismatch_cnt <= '0;
    end else begin
      mismatch <= mismatch_now;
      if (mismatch_now && (mismatch_cnt != '1))
        mismatch_cnt <= mismatch_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_half_adder_fault.sv
// Directed bench: golden truth table, fault-transform table, duration/override/reset/saturation sequences.
module tb_half_adder_fault;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       a, b;
  logic       fault_we;
  logic [1:0] fault_sel, fault_type;
  logic [7:0] fault_dur;

  logic        sum, carry, sum_golden, carry_golden, fault_active, mismatch;
  logic [15:0] mismatch_cnt;
  logic        sum_s, carry_s, sum_golden_s, carry_golden_s, fault_active_s, mismatch_s;
  logic [1:0]  mismatch_cnt_s;

  int n_cmp  = 0;
  int n_fail = 0;

  half_adder_fault #(.DUR_W(8), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b),
    .sum(sum), .carry(carry), .sum_golden(sum_golden), .carry_golden(carry_golden),
    .fault_we(fault_we), .fault_sel(fault_sel), .fault_type(fault_type), .fault_dur(fault_dur),
    .fault_active(fault_active), .mismatch(mismatch), .mismatch_cnt(mismatch_cnt)
  );

  half_adder_fault #(.DUR_W(8), .CNT_W(2)) dut_small (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b),
    .sum(sum_s), .carry(carry_s), .sum_golden(sum_golden_s), .carry_golden(carry_golden_s),
    .fault_we(fault_we), .fault_sel(fault_sel), .fault_type(fault_type), .fault_dur(fault_dur),
    .fault_active(fault_active_s), .mismatch(mismatch_s), .mismatch_cnt(mismatch_cnt_s)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [1:0] sel, input logic [1:0] ft, input logic [7:0] dur);
    fault_sel  = sel;
    fault_type = ft;
    fault_dur  = dur;
    fault_we   = 1'b1;
    tick();
    fault_we   = 1'b0;
  endtask

  typedef struct {
    logic a, b, sum, carry;
  } gold_vec_t;

  typedef struct {
    logic [1:0] sel, ftype;
    logic       a, b, sum, carry, active;
  } fault_vec_t;

  gold_vec_t  gv[4];
  fault_vec_t fv[8];
  logic [15:0] saved_cnt;

  initial begin
    gv[0] = '{1'b0, 1'b0, 1'b0, 1'b0};
    gv[1] = '{1'b0, 1'b1, 1'b1, 1'b0};
    gv[2] = '{1'b1, 1'b0, 1'b1, 1'b0};
    gv[3] = '{1'b1, 1'b1, 1'b0, 1'b1};

    fv[0] = '{2'b01, 2'b01, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    fv[1] = '{2'b01, 2'b10, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    fv[2] = '{2'b10, 2'b10, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    fv[3] = '{2'b11, 2'b11, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    fv[4] = '{2'b10, 2'b11, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    fv[5] = '{2'b00, 2'b11, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    fv[6] = '{2'b11, 2'b00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    fv[7] = '{2'b11, 2'b01, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};

    rst_n = 1'b0; a = 1'b0; b = 1'b0;
    fault_we = 1'b0; fault_sel = 2'b00; fault_type = 2'b00; fault_dur = 8'd0;
    tick();
    tick();
    chk("reset_active", fault_active, 0);
    chk("reset_mismatch", mismatch, 0);
    chk("reset_cnt", mismatch_cnt, 0);
    rst_n = 1'b1;

    // Golden truth table, no fault loaded.
    for (int i = 0; i < 4; i++) begin
      a = gv[i].a; b = gv[i].b;
      #1;
      chk("nofault_sum", sum, gv[i].sum);
      chk("nofault_carry", carry, gv[i].carry);
      chk("golden_sum", sum_golden, gv[i].sum);
      chk("golden_carry", carry_golden, gv[i].carry);
      tick();
    end
    chk("nofault_cnt", mismatch_cnt, 0);
    chk("nofault_mismatch", mismatch, 0);

    // Permanent faults of every kind on every target.
    for (int i = 0; i < 8; i++) begin
      load(fv[i].sel, fv[i].ftype, 8'd0);
      a = fv[i].a; b = fv[i].b;
      #1;
      chk("tbl_sum", sum, fv[i].sum);
      chk("tbl_carry", carry, fv[i].carry);
      chk("tbl_active", fault_active, fv[i].active);
    end

    // Stuck-at-1 on sum, permanent.
    a = 1'b1; b = 1'b1;
    load(2'b01, 2'b10, 8'd0);
    #1;
    chk("sa1_sum", sum, 1);
    chk("sa1_carry", carry, 1);
    tick();
    chk("sa1_mismatch", mismatch, 1);
    for (int k = 0; k < 4; k++) tick();
    chk("sa1_still_active", fault_active, 1);

    // Invert both for 3 cycles.
    a = 1'b1; b = 1'b0;
    load(2'b11, 2'b11, 8'd3);
    for (int k = 0; k < 3; k++) begin
      chk("dur3_sum", sum, 0);
      chk("dur3_carry", carry, 1);
      chk("dur3_active", fault_active, 1);
      tick();
    end
    chk("dur3_expired_active", fault_active, 0);
    chk("dur3_expired_sum", sum, 1);
    chk("dur3_expired_carry", carry, 0);

    // Reload mid-fault restarts the duration.
    load(2'b01, 2'b11, 8'd2);
    tick();
    load(2'b01, 2'b11, 8'd3);
    tick();
    tick();
    chk("reload_active", fault_active, 1);
    tick();
    chk("reload_expired", fault_active, 0);

    // Stuck-at-0 on carry with carry already 0: invisible fault.
    a = 1'b0; b = 1'b0;
    load(2'b10, 2'b01, 8'd0);
    saved_cnt = mismatch_cnt;
    #1;
    chk("sa0_carry", carry, 0);
    chk("sa0_active", fault_active, 1);
    tick();
    tick();
    chk("sa0_mismatch", mismatch, 0);
    chk("sa0_cnt", mismatch_cnt, saved_cnt);

    // Reset clears a live permanent fault; fault_we held during reset is ignored.
    load(2'b01, 2'b11, 8'd0);
    tick();
    tick();
    chk("pre_rst_cnt_nonzero", mismatch_cnt != 0, 1);
    rst_n = 1'b0;
    fault_sel = 2'b11; fault_type = 2'b10; fault_dur = 8'd0; fault_we = 1'b1;
    a = 1'b1; b = 1'b1;
    tick();
    chk("rst_active", fault_active, 0);
    chk("rst_cnt", mismatch_cnt, 0);
    chk("rst_mismatch", mismatch, 0);
    chk("rst_sum", sum, 0);
    chk("rst_carry", carry, 1);
    rst_n = 1'b1;
    fault_we = 1'b0;
    tick();
    chk("post_rst_active", fault_active, 0);
    chk("post_rst_sum", sum, 0);

    // Counter saturation on the 2-bit instance versus the 16-bit one.
    a = 1'b0; b = 1'b0;
    load(2'b01, 2'b11, 8'd0);
    for (int k = 1; k <= 6; k++) begin
      tick();
      chk("sat_cnt_small", mismatch_cnt_s, (k > 3) ? 3 : k);
      chk("sat_cnt_wide", mismatch_cnt, k);
    end
    chk("sat_small_mismatch", mismatch_s, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
